multi_way_traffic_lights: RTL and testbench

Parametrised N-way junction controller: the successor to the fixed two-way, free-running 8-state sequencer. Each way follows the red, red+amber, green, amber sequence, with an all-red gap between ways. Phase durations are counted in `tick` enables, and ways can be skipped when they have no pending demand. A `flash` input forces a fault mode with all ambers flashing. The block sits at the junction top level, driven by a shared prescaler tick.

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/traffic_rr_pick.sv | 29 ++
 rtl/multi_way_traffic_lights.sv | 167 ++++++++++++++++
 tb/tb_multi_way_traffic_lights.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the multi-way junction controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED,
        RED_AMBER,
        GREEN,
        AMBER,
        FLASH
    } phase_e;

    // Lamp triple per way: bit2 red, bit1 amber, bit0 green
    localparam logic [2:0] LAMP_RED       = 3'b100;
    localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
    localparam logic [2:0] LAMP_GREEN     = 3'b001;
    localparam logic [2:0] LAMP_AMBER     = 3'b010;
    localparam logic [2:0] LAMP_OFF       = 3'b000;

    // Longest of the phase durations; sizes the shared phase timer
    function automatic int max_dur(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// Round-robin picker: first way with a pending request after cur, wrapping,
// with cur itself searched last.
module traffic_rr_pick #(
    parameter int N_WAYS = 2
) (
    input  logic [N_WAYS-1:0]         pend,
    input  logic [$clog2(N_WAYS)-1:0] cur,
    output logic [$clog2(N_WAYS)-1:0] next_way,
    output logic                      found
);
    localparam int AW = $clog2(N_WAYS);

    logic [AW-1:0] idx;

    // Scan offsets 1..N_WAYS from cur and keep the first set latch
    always_comb begin
        next_way = cur;
        found    = 1'b0;
        idx      = cur;
        for (int k = 1; k <= N_WAYS; k++) begin
            idx = AW'((int'(cur) + k) % N_WAYS);
            if (!found && pend[idx]) begin
                found    = 1'b1;
                next_way = idx;
            end
        end
    end

endmodule

// File: rtl/multi_way_traffic_lights.sv
// N-way junction controller: one way at a time runs red+amber, green, amber,
// separated by an all-red gap; optional demand skipping and a flashing-amber
// fault mode. All lamp outputs are registered.
module multi_way_traffic_lights
    import traffic_pkg::*;
#(
    parameter int N_WAYS          = 2,
    parameter int GREEN_TICKS     = 4,
    parameter int AMBER_TICKS     = 1,
    parameter int RED_AMBER_TICKS = 1,
    parameter int ALL_RED_TICKS   = 1,
    parameter int FLASH_TICKS     = 2,
    parameter int SKIP_IDLE       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic [N_WAYS-1:0]         req,
    input  logic                      flash,
    output logic [3*N_WAYS-1:0]       lights,
    output logic [$clog2(N_WAYS)-1:0] active_way,
    output logic                      in_flash
);
    localparam int AW   = $clog2(N_WAYS);
    localparam int MAXD = max_dur(GREEN_TICKS, AMBER_TICKS, RED_AMBER_TICKS,
                                  ALL_RED_TICKS, FLASH_TICKS);
    localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [TW-1:0] T_GREEN     = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0] T_AMBER     = TW'(AMBER_TICKS - 1);
    localparam logic [TW-1:0] T_RED_AMBER = TW'(RED_AMBER_TICKS - 1);
    localparam logic [TW-1:0] T_ALL_RED   = TW'(ALL_RED_TICKS - 1);
    localparam logic [TW-1:0] T_FLASH     = TW'(FLASH_TICKS - 1);

    phase_e                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [AW-1:0]         active_q, active_d;
    logic [N_WAYS-1:0]     pend_q, pend_d;
    logic                  flash_on_q, flash_on_d;
    logic [3*N_WAYS-1:0]   lights_q;
    logic                  in_flash_q;
    logic [AW-1:0]         pick_way, seq_way;
    logic                  pick_found;

    traffic_rr_pick #(.N_WAYS(N_WAYS)) u_pick (
        .pend     (pend_q),
        .cur      (active_q),
        .next_way (pick_way),
        .found    (pick_found)
    );

    assign seq_way = (active_q == AW'(N_WAYS - 1)) ? '0 : active_q + AW'(1);

    // Lamp pattern for a given phase, owning way and flash phase
    function automatic logic [3*N_WAYS-1:0] decode(input phase_e st,
                                                   input logic [AW-1:0] way,
                                                   input logic fon);
        logic [3*N_WAYS-1:0] l;
        l = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            if (st == FLASH) begin
                l[3*i +: 3] = fon ? LAMP_AMBER : LAMP_OFF;
            end else if (AW'(i) == way) begin
                case (st)
                    RED_AMBER: l[3*i +: 3] = LAMP_RED_AMBER;
                    GREEN:     l[3*i +: 3] = LAMP_GREEN;
                    AMBER:     l[3*i +: 3] = LAMP_AMBER;
                    default:   l[3*i +: 3] = LAMP_RED;
                endcase
            end else begin
                l[3*i +: 3] = LAMP_RED;
            end
        end
        return l;
    endfunction

    // Next-state: flash override, phase timer, way selection, request latches
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        active_d   = active_q;
        flash_on_d = flash_on_q;
        pend_d     = pend_q | req;
        if (flash) begin
            if (state_q != FLASH) begin
                // Entry ignores any coincident tick: timer loads undecremented
                state_d    = FLASH;
                flash_on_d = 1'b1;
                timer_d    = T_FLASH;
            end else if (tick) begin
                if (timer_q == '0) begin
                    flash_on_d = ~flash_on_q;
                    timer_d    = T_FLASH;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
        end else if (state_q == FLASH) begin
            // Resume with a full all-red gap; active way kept so the next way follows
            state_d    = ALL_RED;
            timer_d    = T_ALL_RED;
            flash_on_d = 1'b0;
        end else if (tick) begin
            if (timer_q != '0) begin
                timer_d = timer_q - TW'(1);
            end else begin
                case (state_q)
                    ALL_RED: begin
                        if (SKIP_IDLE == 0) begin
                            active_d = seq_way;
                            state_d  = RED_AMBER;
                            timer_d  = T_RED_AMBER;
                        end else if (pick_found) begin
                            active_d = pick_way;
                            state_d  = RED_AMBER;
                            timer_d  = T_RED_AMBER;
                        end
                    end
                    RED_AMBER: begin
                        // Clearing on green entry beats a request in the same cycle
                        state_d          = GREEN;
                        timer_d          = T_GREEN;
                        pend_d[active_q] = 1'b0;
                    end
                    GREEN: begin
                        state_d = AMBER;
                        timer_d = T_AMBER;
                    end
                    AMBER: begin
                        state_d = ALL_RED;
                        timer_d = T_ALL_RED;
                    end
                    default: begin
                        state_d = ALL_RED;
                        timer_d = T_ALL_RED;
                    end
                endcase
            end
        end
    end

    // State registers and registered Moore outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ALL_RED;
            timer_q    <= T_ALL_RED;
            active_q   <= AW'(N_WAYS - 1);
            pend_q     <= '0;
            flash_on_q <= 1'b0;
            lights_q   <= {N_WAYS{LAMP_RED}};
            in_flash_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            flash_on_q <= flash_on_d;
            lights_q   <= decode(state_d, active_d, flash_on_d);
            in_flash_q <= (state_d == FLASH);
        end
    end

    assign lights     = lights_q;
    assign active_way = active_q;
    assign in_flash   = in_flash_q;

endmodule

// File: tb/tb_multi_way_traffic_lights.sv
// Bench for multi_way_traffic_lights: a free-running 3-way instance checked
// cycle by cycle against a tick-counting schedule model, and a 4-way
// demand-skipping instance checked against a request-set model.
module tb_multi_way_traffic_lights;

    localparam int NA = 3, GA = 4, AA = 2, RAA = 1, ARA = 1, FA = 2;
    localparam int PER_A = RAA + GA + AA + ARA;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, tick_a, flash_a, in_flash_a;
    logic [NA-1:0]     req_a;
    logic [3*NA-1:0]   lights_a;
    logic [1:0]        active_a;

    logic              rst_b, tick_b, flash_b, in_flash_b;
    logic [NB-1:0]     req_b;
    logic [3*NB-1:0]   lights_b;
    logic [1:0]        active_b;

    multi_way_traffic_lights #(
        .N_WAYS(NA), .GREEN_TICKS(GA), .AMBER_TICKS(AA), .RED_AMBER_TICKS(RAA),
        .ALL_RED_TICKS(ARA), .FLASH_TICKS(FA), .SKIP_IDLE(0)
    ) dut_a (
        .clk(clk), .rst(rst_a), .tick(tick_a), .req(req_a), .flash(flash_a),
        .lights(lights_a), .active_way(active_a), .in_flash(in_flash_a)
    );

    multi_way_traffic_lights #(
        .N_WAYS(NB), .GREEN_TICKS(2), .AMBER_TICKS(1), .RED_AMBER_TICKS(1),
        .ALL_RED_TICKS(1), .FLASH_TICKS(2), .SKIP_IDLE(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .tick(tick_b), .req(req_b), .flash(flash_b),
        .lights(lights_b), .active_way(active_b), .in_flash(in_flash_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Schedule model for instance A: ticks since (re)start and the first way served
    int m_a, base_a, f_a, saved_a;
    bit fl_m;

    // Request-set model for instance B
    logic [NB-1:0] pend_m;
    int            cur_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_active_a();
        if (fl_m) return saved_a;
        if (m_a < ARA) return (base_a + NA - 1) % NA;
        return (base_a + (m_a - ARA) / PER_A) % NA;
    endfunction

    // Position inside the active way's cycle, -1 for the initial all-red gap or flash
    function automatic int phase_a();
        if (fl_m || m_a < ARA) return -1;
        return (m_a - ARA) % PER_A;
    endfunction

    function automatic logic [8:0] exp_lights_a();
        logic [8:0] l;
        int q;
        l = 9'h124;
        if (fl_m) return (((f_a / FA) % 2) == 0) ? 9'h092 : 9'h000;
        q = phase_a();
        if (q < 0) return l;
        if (q < RAA)                l[3*exp_active_a() +: 3] = 3'b110;
        else if (q < RAA + GA)      l[3*exp_active_a() +: 3] = 3'b001;
        else if (q < RAA + GA + AA) l[3*exp_active_a() +: 3] = 3'b010;
        return l;
    endfunction

    function automatic int nonred(input logic [11:0] l, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            logic [11:0] s;
            s = l >> (3 * i);
            if (s[2:0] != 3'b100) c++;
        end
        return c;
    endfunction

    task automatic check_a();
        chk("a_lights", 32'(lights_a), 32'(exp_lights_a()));
        chk("a_active", 32'(active_a), 32'(exp_active_a()));
        chk("a_in_flash", 32'(in_flash_a), 32'(fl_m));
        if (!in_flash_a) chk("a_safety", 32'(nonred(12'(lights_a), NA) <= 1), 32'd1);
    endtask

    task automatic step_a(input bit t, input bit fl);
        tick_a  = t;
        flash_a = fl;
        @(posedge clk);
        if (fl) begin
            if (!fl_m) begin
                saved_a = exp_active_a();
                fl_m    = 1'b1;
                f_a     = 0;
            end else if (t) begin
                f_a++;
            end
        end else if (fl_m) begin
            fl_m   = 1'b0;
            base_a = (saved_a + 1) % NA;
            m_a    = 0;
        end else if (t) begin
            m_a++;
        end
        @(negedge clk);
        check_a();
    endtask

    function automatic int pick_m(input logic [NB-1:0] p, input int cur);
        for (int k = 1; k <= NB; k++) if (p[(cur + k) % NB]) return (cur + k) % NB;
        return -1;
    endfunction

    function automatic int green_way_b();
        for (int i = 0; i < NB; i++) if (lights_b[3*i +: 3] == 3'b001) return i;
        return -1;
    endfunction

    task automatic step_b(input logic [NB-1:0] r);
        req_b  = r;
        tick_b = 1'b1;
        @(posedge clk);
        pend_m |= r;
        @(negedge clk);
        req_b = '0;
        if (!in_flash_b) chk("b_safety", 32'(nonred(lights_b, NB) <= 1), 32'd1);
    endtask

    task automatic hold_b(input int n);
        for (int i = 0; i < n; i++) begin
            step_b('0);
            chk("b_hold_red", 32'(lights_b), 32'h924);
            chk("b_hold_active", 32'(active_b), 32'(cur_m));
        end
    endtask

    // Wait for the next green, check its way, optionally re-request during it
    task automatic serve_b(input bit rearm);
        int  exp;
        bit  seen;
        exp  = pick_m(pend_m, cur_m);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step_b('0);
            if (green_way_b() >= 0) seen = 1'b1;
        end
        chk("b_green_seen", 32'(seen), 32'd1);
        chk("b_green_way", 32'(green_way_b()), 32'(exp));
        chk("b_green_active", 32'(active_b), 32'(exp));
        if (exp >= 0) begin
            pend_m[exp] = 1'b0;
            cur_m       = exp;
        end
        if (rearm && exp >= 0) step_b(NB'(1) << exp);
        seen = 1'b1;
        for (int k = 0; k < 40 && seen; k++) begin
            step_b('0);
            if (green_way_b() < 0) seen = 1'b0;
        end
        chk("b_green_ended", 32'(seen), 32'd0);
    endtask

    initial begin
        bit reached;
        rst_a = 1'b1; tick_a = 1'b0; flash_a = 1'b0; req_a = '0;
        rst_b = 1'b1; tick_b = 1'b0; flash_b = 1'b0; req_b = '0;
        m_a = 0; base_a = 0; f_a = 0; saved_a = 0; fl_m = 1'b0;
        pend_m = '0; cur_m = NB - 1;
        repeat (2) @(negedge clk);
        check_a();
        rst_a = 1'b0;

        // Free-running, then tick every 4th clk, then random ticks
        repeat (48) step_a(1'b1, 1'b0);
        for (int i = 0; i < 96; i++) step_a(i % 4 == 3, 1'b0);
        repeat (100) step_a($urandom_range(0, 2) == 0, 1'b0);

        // Reset in the middle of amber
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            step_a(1'b1, 1'b0);
            if (phase_a() >= RAA + GA && phase_a() < RAA + GA + AA) reached = 1'b1;
        end
        chk("a_reach_amber", 32'(reached), 32'd1);
        #2 rst_a = 1'b1;
        #1;
        chk("a_rst_lights", 32'(lights_a), 32'h124);
        chk("a_rst_in_flash", 32'(in_flash_a), 32'd0);
        chk("a_rst_active", 32'(active_a), 32'(NA - 1));
        m_a = 0; base_a = 0; fl_m = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        check_a();
        repeat (30) step_a(1'b1, 1'b0);

        // Flash entered mid-green, held through regular then random ticks, released
        reached = 1'b0;
        for (int k = 0; k < 40 && !reached; k++) begin
            step_a(1'b1, 1'b0);
            if (phase_a() >= RAA + 1 && phase_a() < RAA + GA) reached = 1'b1;
        end
        chk("a_reach_green", 32'(reached), 32'd1);
        repeat (10) step_a(1'b1, 1'b1);
        repeat (12) step_a($urandom_range(0, 1) == 1, 1'b1);
        repeat (30) step_a(1'b1, 1'b0);
        repeat (60) step_a($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
        repeat (30) step_a(1'b1, 1'b0);

        // Demand-skipping instance
        chk("b_rst_lights", 32'(lights_b), 32'h924);
        chk("b_rst_active", 32'(active_b), 32'(NB - 1));
        chk("b_rst_in_flash", 32'(in_flash_b), 32'd0);
        rst_b = 1'b0;
        hold_b(20);
        step_b(4'b0100);
        serve_b(1'b0);
        hold_b(12);
        step_b(4'b1000);
        serve_b(1'b0);
        step_b(4'b1001);
        serve_b(1'b0);
        serve_b(1'b0);
        hold_b(6);
        step_b(4'b0010);
        serve_b(1'b1);
        serve_b(1'b0);
        hold_b(20);
        for (int r = 0; r < 6; r++) begin
            step_b(NB'($urandom_range(1, 15)));
            while (pend_m != '0) serve_b(1'b0);
        end
        hold_b(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
